// File: rtl/pe_accumulator_pkg.sv
// pe_accumulator_pkg: shared PE datapath widths and accumulator FSM encoding,
// common to the adder stage and the accumulator.
package pe_accumulator_pkg;

    localparam int PE_DATA_W = 20;
    localparam int PE_CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pe_state_e;

endpackage

// File: rtl/pe_accumulator_if.sv
// pe_accumulator_if: control, feedback and result handshake between the PE
// adder stage and its accumulator.
interface pe_accumulator_if
    import pe_accumulator_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int CNT_W  = PE_CNT_W
);
    logic              clr;
    logic              start;
    logic [CNT_W-1:0]  cfg_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pe_sum;
    logic [DATA_W-1:0] prev_sum;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    modport master (
        output clr, start, cfg_len, in_valid, pe_sum, out_ready,
        input  in_ready, prev_sum, out_valid, out_data, busy
    );

    modport slave (
        input  clr, start, cfg_len, in_valid, pe_sum, out_ready,
        output in_ready, prev_sum, out_valid, out_data, busy
    );
endinterface

// File: rtl/pe_result_fifo.sv
// pe_result_fifo: small result FIFO; a pop on an empty buffer is ignored, so a
// same-cycle push into an empty buffer only becomes visible next cycle.
module pe_result_fifo #(
    parameter int DATA_W     = 20,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full     = count_q == CNT_W'(FIFO_DEPTH);
    assign empty    = count_q == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ((wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = do_pop ? ((rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = (do_push && !do_pop) ? count_q + 1'b1 :
                   (!do_push && do_pop) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/pe_accumulator.sv
// pe_accumulator: holds the running partial sum fed back to the PE adder and
// buffers the final sum of each run for a downstream consumer.
module pe_accumulator
    import pe_accumulator_pkg::*;
#(
    parameter int DATA_W     = PE_DATA_W,
    parameter int CNT_W      = PE_CNT_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pe_accumulator_if.slave    bus
);
    pe_state_e         state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              last_beat, accept, push, full, empty;

    // Stall uses the registered full flag so a same-cycle pop cannot unblock it.
    assign last_beat    = cnt_q == len_q - 1'b1;
    assign bus.in_ready = (state_q == RUN) && !(last_beat && full);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && last_beat && !bus.clr;
    assign bus.prev_sum = (state_q == RUN) ? acc_q : '0;
    assign bus.busy     = state_q == RUN;
    assign bus.out_valid = !empty;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (bus.clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (state_q == IDLE) begin
            if (bus.start && bus.cfg_len != '0) begin
                state_d = RUN;
                len_d   = bus.cfg_len;
                cnt_d   = '0;
                acc_d   = '0;
            end
        end else if (accept) begin
            state_d = last_beat ? IDLE : RUN;
            cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
            acc_d   = last_beat ? '0 : bus.pe_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    pe_result_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.pe_sum),
        .pop       (bus.out_ready),
        .pop_data  (bus.out_data),
        .full      (full),
        .empty     (empty)
    );
endmodule

// File: doc/pe_accumulator.md
PE_ACCUMULATOR -- requirements
Module: pe_accumulator

Interface
REQ-001 Parameter DATA_W, default 20: width of the partial-sum, feedback and result data paths.
REQ-002 Parameter CNT_W, default 8: width of the accumulation-length field.
REQ-003 Parameter FIFO_DEPTH, default 2: number of result entries in the output buffer.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 clr  in  1  synchronous abort of the current accumulation.
REQ-007 start  in  1  begins an accumulation run; cfg_len is sampled in the same cycle.
REQ-008 cfg_len  in  CNT_W  number of beats in the run, unsigned.
REQ-009 in_valid  in  1  pe_sum is valid this cycle.
REQ-010 in_ready  out  1  the block accepts pe_sum this cycle.
REQ-011 pe_sum  in  DATA_W  signed result from the PE adder stage; it already includes prev_sum.
REQ-012 prev_sum  out  DATA_W  signed running accumulator, fed back to the adder's previous_sum input.
REQ-013 out_valid  out  1  the output buffer holds at least one result.
REQ-014 out_ready  in  1  the consumer takes out_data this cycle.
REQ-015 out_data  out  DATA_W  signed result at the head of the output buffer.
REQ-016 busy  out  1  high while state is RUN.

Function
REQ-017 FSM states are IDLE and RUN.
REQ-018 In IDLE: in_ready=0 and prev_sum=0.
REQ-019 IDLE->RUN on start=1 with cfg_len!=0 and clr=0: len_q<=cfg_len, beat counter<=0, acc<=0.
REQ-020 start with cfg_len==0 is ignored; state stays IDLE and no result is produced.
REQ-021 start while in RUN is ignored.
REQ-022 A beat is accepted when in_valid && in_ready; accept sets acc<=pe_sum and increments the beat counter.
REQ-023 prev_sum SHALL equal acc combinationally, with no added latency.
REQ-024 in_ready = (state==RUN) && !(last_beat && fifo_full), where last_beat = (counter==len_q-1).
REQ-025 Full-buffer stall decision uses the registered full flag only; a pop in the same cycle does not unblock the last beat.
REQ-026 On the accepted last beat: pe_sum is pushed into the buffer, acc<=0, state->IDLE.
REQ-027 The first result is visible on out_data/out_valid one cycle after the last beat is accepted.
REQ-028 Arithmetic is two's-complement DATA_W; the block performs no saturation and no overflow detection (wraps as the adder does).
REQ-029 Buffer is a FIFO: pop on out_valid && out_ready; out_data shows the head entry; out_data=0 when the buffer is empty.
REQ-030 Simultaneous push and pop with 0<count<FIFO_DEPTH: count is unchanged and order is preserved.
REQ-031 Push and pop in the same cycle on an empty buffer: no pop occurs; the entry becomes visible next cycle.
REQ-032 clr=1: state->IDLE, acc<=0, counter<=0; buffer contents are preserved; clr has priority over start and over a same-cycle beat accept.
REQ-033 busy=1 exactly while state==RUN.

Reset
REQ-034 rst_n=0 asynchronously forces IDLE, acc=0, counter=0, len_q=0, buffer empty (read/write pointers and count 0).
REQ-035 During reset: in_ready=0, out_valid=0, out_data=0, prev_sum=0, busy=0.
REQ-036 Reset asserted mid-run discards the partial sum and all buffered results.
REQ-037 First start is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-038 DATA_W/CNT_W defaults and the state encoding (IDLE=0, RUN=1) belong in the shared PE package used with the adder stage.
REQ-039 The output buffer is one sub-module, pe_result_fifo, parameterised by DATA_W and FIFO_DEPTH, with push/pop/full/empty ports.

Verification
REQ-040 Run of 3: start, cfg_len=3, beats pe_sum=5,12,-4 with prev_sum checked as 0,5,12 -> one result -4 (0xFFFFC); out_valid one cycle after the 3rd beat.
REQ-041 Backpressure: 3 runs of length 1 (values 1,2,3) with out_ready=0 -> results 1,2 buffered; in_ready=0 on the third run's beat; release out_ready -> outputs 1,2,3 in order.
REQ-042 cfg_len=0 start -> busy stays 0, in_ready stays 0, no output.
REQ-043 clr after 2 of 4 beats of a run -> state IDLE, prev_sum=0, no result, prior buffered result intact; clr and start in the same cycle -> stays IDLE.
REQ-044 Wrap: beats 0x7FFFF then 1 in a run of 2 -> result 0x80000.
REQ-045 rst_n low mid-run with one result buffered -> all outputs 0 immediately, buffer empty after release.
